// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_pkg
// Description : Shared types and constants for the 8x8 2D DCT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package dct_pkg;

  localparam int DCT_N          = 8;
  localparam int DCT_DATA_WIDTH = 32;

  typedef logic signed [DCT_DATA_WIDTH-1:0] dct_sample_t;
  typedef dct_sample_t [DCT_N-1:0]          dct_row_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } tbuf_rd_state_e;

endpackage : dct_pkg
`default_nettype wire

// File: rtl/dct_tbuf_bank.sv
`default_nettype none
// ============================================================================
// Module      : dct_tbuf_bank
// Description : One NxN sample bank, written a row at a time, read a column.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_tbuf_bank
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_WIDTH,
  parameter int N          = DCT_N
) (
  input  logic                         CLOCK,
  input  logic                         i_we,
  input  logic [2:0]                   i_row,
  input  logic signed [DATA_WIDTH-1:0] i_data [N],
  input  logic [2:0]                   i_col,
  output logic signed [DATA_WIDTH-1:0] o_data [N]
);

  // Contents are never reset; a block is always fully written before it is read.
  logic signed [DATA_WIDTH-1:0] r_mem [N][N];

  always_ff @(posedge CLOCK) begin
    if (i_we) begin
      for (int j = 0; j < N; j++) begin
        r_mem[i_row][j] <= i_data[j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_data[i] = r_mem[i][i_col];
    end
  end

endmodule : dct_tbuf_bank
`default_nettype wire

// File: rtl/dct_transpose_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dct_transpose_buffer
// Description : Ping-pong 8x8 row-in / column-out transpose between DCT passes.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_WIDTH,
  parameter int N          = DCT_N
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         input_valid,
  input  logic signed [DATA_WIDTH-1:0] DATA [N],
  output logic                         output_valid,
  output logic signed [DATA_WIDTH-1:0] OUT_DATA [N],
  output logic [2:0]                   output_col,
  output logic                         output_last
);

  localparam logic [2:0] C_LAST_IDX = 3'd7;

  generate
    if (N != 8) begin : g_n_check
      $error("dct_transpose_buffer: only N == 8 is supported");
    end
  endgenerate

  logic [2:0]                   r_wr_row;
  logic                         r_wr_bank;
  logic                         w_launch;
  tbuf_rd_state_e               r_state;
  tbuf_rd_state_e               w_state_nxt;
  logic                         r_rd_bank;
  logic                         w_rd_bank_nxt;
  logic [2:0]                   r_rd_col;
  logic [2:0]                   w_rd_col_nxt;
  logic signed [DATA_WIDTH-1:0] w_bank_rd [2][N];
  logic signed [DATA_WIDTH-1:0] w_rd_data [N];
  logic                         r_out_valid;
  logic [2:0]                   r_out_col;
  logic                         r_out_last;
  logic signed [DATA_WIDTH-1:0] r_out_data [N];

  assign w_launch = input_valid && (r_wr_row == C_LAST_IDX);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_wr_row  <= '0;
      r_wr_bank <= 1'b0;
    end else if (input_valid) begin
      r_wr_row <= r_wr_row + 3'd1;
      if (w_launch) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  generate
    for (genvar k = 0; k < 2; k++) begin : g_bank
      dct_tbuf_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N)
      ) u_bank (
        .CLOCK  (CLOCK),
        .i_we   (input_valid && (r_wr_bank == 1'(k))),
        .i_row  (r_wr_row),
        .i_data (DATA),
        .i_col  (r_rd_col),
        .o_data (w_bank_rd[k])
      );
    end
  endgenerate

  assign w_rd_data = r_rd_bank ? w_bank_rd[1] : w_bank_rd[0];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_rd_bank <= 1'b0;
      r_rd_col  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_rd_col  <= w_rd_col_nxt;
    end
  end

  // A launch landing on column 7 re-arms the drain so blocks stream gap-free.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_col_nxt  = r_rd_col;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt   = ST_DRAIN;
          w_rd_bank_nxt = r_wr_bank;
          w_rd_col_nxt  = '0;
        end
      end
      ST_DRAIN: begin
        w_rd_col_nxt = r_rd_col + 3'd1;
        if (r_rd_col == C_LAST_IDX) begin
          if (w_launch) begin
            w_rd_bank_nxt = r_wr_bank;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_out_data[i] <= '0;
      end
    end else begin
      r_out_valid <= (r_state == ST_DRAIN);
      r_out_col   <= (r_state == ST_DRAIN) ? r_rd_col : 3'd0;
      r_out_last  <= (r_state == ST_DRAIN) && (r_rd_col == C_LAST_IDX);
      if (r_state == ST_DRAIN) begin
        for (int i = 0; i < N; i++) begin
          r_out_data[i] <= w_rd_data[i];
        end
      end
    end
  end

  assign output_valid = r_out_valid;
  assign output_col   = r_out_col;
  assign output_last  = r_out_last;
  assign OUT_DATA     = r_out_data;

endmodule : dct_transpose_buffer
`default_nettype wire
